// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: phase encoding, lamp
// patterns, default intervals and lamp decode helpers.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_G_BASE = 3'd0,
        MAIN_G_EXT  = 3'd1,
        MAIN_Y      = 3'd2,
        WALK        = 3'd3,
        SIDE_G_BASE = 3'd4,
        SIDE_G_EXT  = 3'd5,
        SIDE_Y      = 3'd6
    } state_e;

    // Lamp vectors are {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [3:0] DEF_T_BASE = 4'd6;
    localparam logic [3:0] DEF_T_EXT  = 4'd3;
    localparam logic [3:0] DEF_T_YEL  = 4'd2;

    function automatic logic [2:0] lamp_main(input logic [2:0] s);
        case (s)
            MAIN_G_BASE, MAIN_G_EXT: return GRN;
            MAIN_Y:                  return YEL;
            default:                 return RED;
        endcase
    endfunction

    function automatic logic [2:0] lamp_side(input logic [2:0] s);
        case (s)
            SIDE_G_BASE, SIDE_G_EXT: return GRN;
            SIDE_Y:                  return YEL;
            default:                 return RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_fsm_walk_latch.sv
// Sticky pedestrian request flag: set by any request cycle, cleared on entry
// to the walk phase unless a new request arrives in that same cycle.
module walk_request_latch (
    input  logic clock,
    input  logic reset_sync,
    input  logic walk_request,
    input  logic clear,
    output logic pending
);

    always_ff @(posedge clock) begin
        if (reset_sync) begin
            pending <= 1'b0;
        end else if (walk_request) begin
            pending <= 1'b1;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Intersection phase sequencer: steps main/side/walk phases on timer expiry
// and programs the interval timer for each phase it enters.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter logic [3:0] T_BASE = DEF_T_BASE,
    parameter logic [3:0] T_EXT  = DEF_T_EXT,
    parameter logic [3:0] T_YEL  = DEF_T_YEL
) (
    input  logic       clock,
    input  logic       reset_sync,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] value,
    output logic [2:0] light_main,
    output logic [2:0] light_side,
    output logic       walk
);

    logic [2:0] state;
    logic [2:0] state_next;
    logic [3:0] interval_next;
    logic       kick;
    logic       illegal;
    logic       advance;
    logic       enter_walk;
    logic       walk_pending;

    always_comb begin
        state_next = state;
        illegal    = 1'b0;
        case (state)
            MAIN_G_BASE: state_next = sensor ? MAIN_G_EXT : MAIN_Y;
            MAIN_G_EXT:  state_next = MAIN_Y;
            MAIN_Y:      state_next = walk_pending ? WALK : SIDE_G_BASE;
            WALK:        state_next = SIDE_G_BASE;
            SIDE_G_BASE: state_next = sensor ? SIDE_G_EXT : SIDE_Y;
            SIDE_G_EXT:  state_next = SIDE_Y;
            SIDE_Y:      state_next = MAIN_G_BASE;
            default: begin
                state_next = MAIN_G_BASE;
                illegal    = 1'b1;
            end
        endcase
    end

    always_comb begin
        case (state_next)
            MAIN_G_BASE, SIDE_G_BASE: interval_next = T_BASE;
            MAIN_Y, SIDE_Y:           interval_next = T_YEL;
            default:                  interval_next = T_EXT;
        endcase
    end

    // Timer load handshake: start_timer is a one-cycle strobe and value is
    // valid whenever it is high. An expiry that coincides with the strobe
    // belongs to the interval being replaced, so it is dropped.
    assign advance    = illegal || (expired && !start_timer && !kick);
    assign enter_walk = advance && !kick && (state_next == WALK);

    always_ff @(posedge clock) begin
        if (reset_sync) begin
            state       <= MAIN_G_BASE;
            kick        <= 1'b1;
            start_timer <= 1'b0;
            value       <= 4'd0;
            light_main  <= GRN;
            light_side  <= RED;
            walk        <= 1'b0;
        end else if (kick) begin
            kick        <= 1'b0;
            start_timer <= 1'b1;
            value       <= T_BASE;
        end else if (advance) begin
            state       <= state_next;
            start_timer <= 1'b1;
            value       <= interval_next;
            light_main  <= lamp_main(state_next);
            light_side  <= lamp_side(state_next);
            walk        <= (state_next == WALK);
        end else begin
            start_timer <= 1'b0;
        end
    end

    walk_request_latch u_walk_latch (
        .clock        (clock),
        .reset_sync   (reset_sync),
        .walk_request (walk_request),
        .clear        (enter_walk),
        .pending      (walk_pending)
    );

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: a bench-side interval timer closes the
// loop, a phase-level model is compared every cycle, literals pin key points.
module tb_traffic_light_fsm;

    localparam logic [3:0] T_BASE = 4'd6;
    localparam logic [3:0] T_EXT  = 4'd3;
    localparam logic [3:0] T_YEL  = 4'd2;
    localparam int         TICK   = 4;

    logic       clock = 1'b0;
    logic       reset_sync;
    logic       sensor;
    logic       walk_request;
    logic       expired;
    logic       start_timer;
    logic [3:0] value;
    logic [2:0] light_main;
    logic [2:0] light_side;
    logic       walk;

    traffic_light_fsm #(
        .T_BASE (T_BASE),
        .T_EXT  (T_EXT),
        .T_YEL  (T_YEL)
    ) dut (
        .clock        (clock),
        .reset_sync   (reset_sync),
        .sensor       (sensor),
        .walk_request (walk_request),
        .expired      (expired),
        .start_timer  (start_timer),
        .value        (value),
        .light_main   (light_main),
        .light_side   (light_side),
        .walk         (walk)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int tcount = 0;
    logic [10:0] exp_q[$];   // {walk, side[2:0], main[2:0], value[3:0]}

    // Phase-level model: phases named by short strings.
    string      m_phase   = "MG";
    logic       m_start   = 1'b0;
    logic       m_kick    = 1'b0;
    logic       m_pending = 1'b0;
    logic [3:0] m_value   = 4'd0;

    function automatic logic [3:0] m_interval(input string p);
        if (p == "MG" || p == "SG") return T_BASE;
        if (p == "MY" || p == "SY") return T_YEL;
        return T_EXT;
    endfunction

    function automatic logic [2:0] m_main(input string p);
        if (p == "MG" || p == "MX") return 3'b001;
        if (p == "MY") return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] m_side(input string p);
        if (p == "SG" || p == "SX") return 3'b001;
        if (p == "SY") return 3'b010;
        return 3'b100;
    endfunction

    function automatic string m_succ(input string p, input logic sens, input logic pend);
        if (p == "MG") return sens ? "MX" : "MY";
        if (p == "MX") return "MY";
        if (p == "MY") return pend ? "WK" : "SG";
        if (p == "WK") return "SG";
        if (p == "SG") return sens ? "SX" : "SY";
        if (p == "SX") return "SY";
        return "MG";
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict outputs after the coming clock edge from the inputs now applied.
    task automatic model_update();
        string nxt;
        logic  entering_walk;
        entering_walk = 1'b0;
        if (reset_sync) begin
            m_phase   = "MG";
            m_start   = 1'b0;
            m_value   = 4'd0;
            m_pending = 1'b0;
            m_kick    = 1'b1;
        end else begin
            if (m_kick) begin
                m_start = 1'b1;
                m_value = T_BASE;
                m_kick  = 1'b0;
            end else if (expired && !m_start) begin
                nxt           = m_succ(m_phase, sensor, m_pending);
                entering_walk = (nxt == "WK");
                m_phase       = nxt;
                m_start       = 1'b1;
                m_value       = m_interval(nxt);
            end else begin
                m_start = 1'b0;
            end
            if (walk_request) m_pending = 1'b1;
            else if (entering_walk) m_pending = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic both_go;
        logic walk_bad;
        check("start_timer", {3'b0, start_timer}, {3'b0, m_start});
        check("value", value, m_value);
        check("light_main", {1'b0, light_main}, {1'b0, m_main(m_phase)});
        check("light_side", {1'b0, light_side}, {1'b0, m_side(m_phase)});
        check("walk", {3'b0, walk}, {3'b0, logic'(m_phase == "WK")});
        both_go  = (|light_main[1:0]) && (|light_side[1:0]);
        walk_bad = walk && !(light_main == 3'b100 && light_side == 3'b100);
        check("streets_exclusive", {3'b0, both_go}, 4'd0);
        check("walk_both_red", {3'b0, walk_bad}, 4'd0);
    endtask

    // Bench-side interval timer: enable tick every TICK clocks.
    task automatic timer_update();
        if (start_timer === 1'b1) begin
            tcount  = TICK * int'(value);
            expired = 1'b0;
        end else if (tcount > 0) begin
            tcount  = tcount - 1;
            expired = (tcount == 0);
        end else begin
            expired = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_update();
        @(negedge clock);
        compare_all();
        timer_update();
    endtask

    task automatic push_load(input logic [3:0] v, input logic [2:0] m,
                             input logic [2:0] s, input logic w);
        exp_q.push_back({w, s, m, v});
    endtask

    task automatic expect_load(input string name);
        logic [10:0] e;
        int          n;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: expected queue empty", name);
            errors++;
            return;
        end
        e = exp_q.pop_front();
        n = 0;
        do begin
            step();
            n++;
        end while (start_timer !== 1'b1 && n < 60);
        check({name, "_start"}, {3'b0, start_timer}, 4'd1);
        check({name, "_value"}, value, e[3:0]);
        check({name, "_main"}, {1'b0, light_main}, {1'b0, e[6:4]});
        check({name, "_side"}, {1'b0, light_side}, {1'b0, e[9:7]});
        check({name, "_walk"}, {3'b0, walk}, {3'b0, e[10]});
    endtask

    task automatic run_until_expired(input string name);
        int n;
        n = 0;
        while (expired !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check(name, {3'b0, expired}, 4'd1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset_sync   = 1'b1;
        sensor       = 1'b0;
        walk_request = 1'b0;
        expired      = 1'b0;
        step();
        step();
        check("rst_start", {3'b0, start_timer}, 4'd0);
        check("rst_value", value, 4'd0);
        check("rst_main", {1'b0, light_main}, 4'b0001);
        check("rst_side", {1'b0, light_side}, 4'b0100);
        check("rst_walk", {3'b0, walk}, 4'd0);

        // Release: timer kicked with the base interval on the first cycle.
        reset_sync = 1'b0;
        step();
        check("kick_start", {3'b0, start_timer}, 4'd1);
        check("kick_value", value, 4'd6);
        check("kick_main", {1'b0, light_main}, 4'b0001);

        // Plain cycle, no sensor, no pedestrian.
        push_load(4'd2, 3'b010, 3'b100, 1'b0);
        push_load(4'd6, 3'b100, 3'b001, 1'b0);
        push_load(4'd2, 3'b100, 3'b010, 1'b0);
        push_load(4'd6, 3'b001, 3'b100, 1'b0);
        expect_load("main_y");
        expect_load("side_g");
        expect_load("side_y");
        expect_load("main_g");

        // Sensor at main-green expiry: one-shot extension, then yellow.
        sensor = 1'b1;
        push_load(4'd3, 3'b001, 3'b100, 1'b0);
        push_load(4'd2, 3'b010, 3'b100, 1'b0);
        expect_load("main_ext");
        expect_load("main_y_after_ext");
        sensor = 1'b0;

        // Single-cycle walk pulse during side green, served after main yellow.
        push_load(4'd6, 3'b100, 3'b001, 1'b0);
        expect_load("side_g2");
        walk_request = 1'b1;
        step();
        walk_request = 1'b0;
        check("model_pending_set", {3'b0, m_pending}, 4'd1);
        push_load(4'd2, 3'b100, 3'b010, 1'b0);
        push_load(4'd6, 3'b001, 3'b100, 1'b0);
        push_load(4'd2, 3'b010, 3'b100, 1'b0);
        push_load(4'd3, 3'b100, 3'b100, 1'b1);
        push_load(4'd6, 3'b100, 3'b001, 1'b0);
        expect_load("side_y2");
        expect_load("main_g2");
        expect_load("main_y2");
        expect_load("walk1");
        expect_load("side_g_after_walk");

        // Expiry coincident with the load strobe is ignored.
        expired = 1'b1;
        step();
        check("coinc_start", {3'b0, start_timer}, 4'd0);
        check("coinc_value", value, 4'd6);
        check("coinc_side", {1'b0, light_side}, 4'b0001);

        // Side extension, then reset mid-extension with a pending request.
        sensor = 1'b1;
        push_load(4'd3, 3'b100, 3'b001, 1'b0);
        expect_load("side_ext");
        sensor = 1'b0;
        walk_request = 1'b1;
        step();
        walk_request = 1'b0;
        step();
        step();
        step();
        reset_sync = 1'b1;
        step();
        reset_sync = 1'b0;
        check("midrst_main", {1'b0, light_main}, 4'b0001);
        check("midrst_side", {1'b0, light_side}, 4'b0100);
        check("midrst_start", {3'b0, start_timer}, 4'd0);
        check("model_pending_rst", {3'b0, m_pending}, 4'd0);
        step();
        check("midrst_kick_start", {3'b0, start_timer}, 4'd1);
        check("midrst_kick_value", value, 4'd6);
        push_load(4'd2, 3'b010, 3'b100, 1'b0);
        push_load(4'd6, 3'b100, 3'b001, 1'b0);
        expect_load("midrst_main_y");
        expect_load("midrst_side_g");

        // Request in the very cycle WALK is entered keeps the flag set.
        walk_request = 1'b1;
        step();
        walk_request = 1'b0;
        push_load(4'd2, 3'b100, 3'b010, 1'b0);
        push_load(4'd6, 3'b001, 3'b100, 1'b0);
        push_load(4'd2, 3'b010, 3'b100, 1'b0);
        expect_load("prio_side_y");
        expect_load("prio_main_g");
        expect_load("prio_main_y");
        run_until_expired("prio_expiry_seen");
        walk_request = 1'b1;
        step();
        walk_request = 1'b0;
        check("prio_walk_lamp", {3'b0, walk}, 4'd1);
        check("prio_walk_value", value, 4'd3);
        check("model_pending_kept", {3'b0, m_pending}, 4'd1);
        push_load(4'd6, 3'b100, 3'b001, 1'b0);
        push_load(4'd2, 3'b100, 3'b010, 1'b0);
        push_load(4'd6, 3'b001, 3'b100, 1'b0);
        push_load(4'd2, 3'b010, 3'b100, 1'b0);
        push_load(4'd3, 3'b100, 3'b100, 1'b1);
        expect_load("prio_side_g");
        expect_load("prio_side_y2");
        expect_load("prio_main_g2");
        expect_load("prio_main_y2");
        expect_load("prio_walk2");
        step();
        step();

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
